// File: rtl/inst_stat_display_if.sv
// Bundle of counter inputs, selection controls and seven-segment outputs
// that connects the statistics counter block to the display driver.
interface inst_stat_display_if;
  logic [15:0] J;
  logic [15:0] B;
  logic [15:0] Br;
  logic [15:0] All;
  logic [1:0]  sel;
  logic        auto;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        busy;

  modport master (output J, B, Br, All, sel, auto, input an, seg, busy);
  modport slave  (input J, B, Br, All, sel, auto, output an, seg, busy);
endinterface

// File: rtl/inst_stat_display.sv
// Shows one of four 16-bit statistics counters in decimal on an 8-digit
// multiplexed seven-segment display, using a sequential double-dabble converter.
module inst_stat_display #(
  parameter int unsigned REFRESH_DIV   = 100000,
  parameter int unsigned ROTATE_FRAMES = 500
) (
  input logic                clk,
  input logic                rst,
  inst_stat_display_if.slave bus
);
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned FRM_W = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(ROTATE_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    case (d)
      4'd0:    digit_glyph = 8'hC0;
      4'd1:    digit_glyph = 8'hF9;
      4'd2:    digit_glyph = 8'hA4;
      4'd3:    digit_glyph = 8'hB0;
      4'd4:    digit_glyph = 8'h99;
      4'd5:    digit_glyph = 8'h92;
      4'd6:    digit_glyph = 8'h82;
      4'd7:    digit_glyph = 8'hF8;
      4'd8:    digit_glyph = 8'h80;
      4'd9:    digit_glyph = 8'h90;
      default: digit_glyph = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] label_glyph(input logic [1:0] l);
    case (l)
      2'd0:    label_glyph = 8'hE1;
      2'd1:    label_glyph = 8'h83;
      2'd2:    label_glyph = 8'hAF;
      2'd3:    label_glyph = 8'h88;
      default: label_glyph = 8'hFF;
    endcase
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  function automatic logic [19:0] dd_adjust(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int k = 0; k < 5; k++) begin
      if (v[4*k +: 4] >= 4'd5) r[4*k +: 4] = v[4*k +: 4] + 4'd3;
      else                     r[4*k +: 4] = v[4*k +: 4];
    end
    return r;
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic [1:0]       rot_q, rot_d;
  state_t           state_q, state_d;
  logic [15:0]      sh_q, sh_d;
  logic [19:0]      bcd_q, bcd_d;
  logic [3:0]       iter_q, iter_d;
  logic [1:0]       lbl_q, lbl_d;
  logic [19:0]      disp_bcd_q, disp_bcd_d;
  logic [1:0]       disp_lbl_q, disp_lbl_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic             busy_q, busy_d;
  logic             tc_s, frame_tick_s;
  logic [1:0]       sel_s;
  logic [15:0]      sel_val_s;
  logic [35:0]      shifted_s;

  // Scan divider, digit index and auto-rotate bookkeeping.
  always_comb begin
    tc_s         = (div_q == DIV_LAST);
    frame_tick_s = tc_s && (idx_q == 3'd7);
    div_d        = tc_s ? {DIV_W{1'b0}} : div_q + {{(DIV_W-1){1'b0}}, 1'b1};
    idx_d        = tc_s ? idx_q + 3'd1 : idx_q;
    frm_d        = frm_q;
    rot_d        = rot_q;
    if (frame_tick_s && bus.auto) begin
      if (frm_q == FRM_LAST) begin
        frm_d = {FRM_W{1'b0}};
        rot_d = rot_q + 2'd1;
      end else begin
        frm_d = frm_q + {{(FRM_W-1){1'b0}}, 1'b1};
      end
    end else begin
      frm_d = frm_q;
    end
  end

  // Counter selection seen by the LOAD state.
  always_comb begin
    sel_s = bus.auto ? rot_q : bus.sel;
    case (sel_s)
      2'd0:    sel_val_s = bus.J;
      2'd1:    sel_val_s = bus.B;
      2'd2:    sel_val_s = bus.Br;
      2'd3:    sel_val_s = bus.All;
      default: sel_val_s = 16'd0;
    endcase
  end

  // Conversion FSM: next state, datapath and busy.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    lbl_d      = lbl_q;
    disp_bcd_d = disp_bcd_q;
    disp_lbl_d = disp_lbl_q;
    busy_d     = 1'b0;
    shifted_s  = {dd_adjust(bcd_q), sh_q} << 1;
    case (state_q)
      S_IDLE: begin
        if (frame_tick_s) state_d = S_LOAD;
        else              state_d = S_IDLE;
      end
      S_LOAD: begin
        sh_d    = sel_val_s;
        bcd_d   = 20'd0;
        iter_d  = 4'd0;
        lbl_d   = sel_s;
        busy_d  = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, sh_d} = shifted_s;
        iter_d = iter_q + 4'd1;
        busy_d = 1'b1;
        if (iter_q == 4'd15) state_d = S_DONE;
        else                 state_d = S_SHIFT;
      end
      S_DONE: begin
        disp_bcd_d = bcd_q;
        disp_lbl_d = lbl_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Glyph for the digit currently being scanned, with leading-zero blanking on 4..1.
  always_comb begin
    an_d = ~(8'd1 << idx_q);
    case (idx_q)
      3'd7:    seg_d = label_glyph(disp_lbl_q);
      3'd6:    seg_d = 8'hFF;
      3'd5:    seg_d = 8'hFF;
      3'd4:    seg_d = (disp_bcd_q[19:16] == 4'd0) ? 8'hFF : digit_glyph(disp_bcd_q[19:16]);
      3'd3:    seg_d = (disp_bcd_q[19:12] == 8'd0) ? 8'hFF : digit_glyph(disp_bcd_q[15:12]);
      3'd2:    seg_d = (disp_bcd_q[19:8] == 12'd0) ? 8'hFF : digit_glyph(disp_bcd_q[11:8]);
      3'd1:    seg_d = (disp_bcd_q[19:4] == 16'd0) ? 8'hFF : digit_glyph(disp_bcd_q[7:4]);
      3'd0:    seg_d = digit_glyph(disp_bcd_q[3:0]);
      default: seg_d = 8'hFF;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= {DIV_W{1'b0}};
      idx_q      <= 3'd0;
      frm_q      <= {FRM_W{1'b0}};
      rot_q      <= 2'd0;
      state_q    <= S_IDLE;
      sh_q       <= 16'd0;
      bcd_q      <= 20'd0;
      iter_q     <= 4'd0;
      lbl_q      <= 2'd0;
      disp_bcd_q <= 20'd0;
      disp_lbl_q <= 2'd0;
      an_q       <= 8'hFF;
      seg_q      <= 8'hFF;
      busy_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      frm_q      <= frm_d;
      rot_q      <= rot_d;
      state_q    <= state_d;
      sh_q       <= sh_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      lbl_q      <= lbl_d;
      disp_bcd_q <= disp_bcd_d;
      disp_lbl_q <= disp_lbl_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.busy = busy_q;
endmodule
